// File: rtl/pcoeff_acc_pkg.sv
// Shared definitions for the pcoeff result accumulator: FSM encoding, error flag
// bit positions and the derived width of the incoming pcoeffSum word.
package pcoeff_acc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_EMIT    = 2'd3
    } acc_state_t;

    localparam int ERR_OVERFLOW   = 0;
    localparam int ERR_START_BUSY = 1;
    localparam int ERR_W          = 2;

    localparam int PCOEFF_COUNT_BITWIDTH_DEF = 10;
    localparam int SUM_IN_WIDTH              = PCOEFF_COUNT_BITWIDTH_DEF + 35;

    // pcoeffSum width tracks the count width of the producing pipeline.
    function automatic int sum_in_width(input int count_w);
        return count_w + 35;
    endfunction

endpackage

// File: rtl/pcoeff_result_accumulator_tracker.sv
// result_read_tracker: follows outstanding results-FIFO reads through the fixed
// read latency and counts requested/received results for the current job.
module result_read_tracker #(
    parameter int READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clear,
    input  logic        i_grab,
    input  logic [31:0] i_expected,
    output logic        o_data_valid,
    output logic        o_all_requested,
    output logic        o_all_received
);

    logic [READ_LATENCY-1:0] r_vld;
    logic [31:0]             r_requested;
    logic [31:0]             r_received;
    logic [31:0]             w_received_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld <= '0;
        end else begin
            r_vld[0] <= i_grab;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_requested <= '0;
            r_received  <= '0;
        end else if (i_clear) begin
            r_requested <= '0;
            r_received  <= '0;
        end else begin
            if (i_grab) begin
                r_requested <= r_requested + 32'd1;
            end
            if (o_data_valid) begin
                r_received <= r_received + 32'd1;
            end
        end
    end

    // Counting the result landing this cycle lets EMIT follow the last data by one cycle.
    assign w_received_next = r_received + 32'(o_data_valid);

    assign o_data_valid    = r_vld[READ_LATENCY-1];
    assign o_all_requested = (r_requested >= i_expected);
    assign o_all_received  = (w_received_next >= i_expected);

endmodule

// File: rtl/pcoeff_result_accumulator.sv
// Pops one result per batch from an aggregating pipeline's results FIFO and sums them
// into a job total handed out on valid/ready. Optional checksum: PCOEFF_ACC_CHECKSUM_EN.
module pcoeff_result_accumulator
    import pcoeff_acc_pkg::*;
#(
    parameter int PCOEFF_COUNT_BITWIDTH = 10,
    parameter int TOTAL_SUM_WIDTH       = 64,
    parameter int TOTAL_COUNT_WIDTH     = 48,
    parameter int READ_LATENCY          = 2
) (
    input  logic                                             clk,
    input  logic                                             rst_n,
    input  logic                                             jobStart,
    input  logic [31:0]                                      jobBatchCount,
    input  logic                                             resultsAvailable,
    output logic                                             grabResults,
    input  logic [sum_in_width(PCOEFF_COUNT_BITWIDTH)-1:0]   pcoeffSum,
    input  logic [PCOEFF_COUNT_BITWIDTH-1:0]                 pcoeffCount,
    output logic                                             totalValid,
    input  logic                                             totalReady,
    output logic [TOTAL_SUM_WIDTH-1:0]                       totalSum,
    output logic [TOTAL_COUNT_WIDTH-1:0]                     totalCount,
    output logic [31:0]                                      totalChecksum,
    output logic                                             busy,
    output logic [1:0]                                       errFlags
);

    acc_state_t                 r_state;
    acc_state_t                 w_next_state;
    logic [31:0]                r_expected;
    logic                       r_grab_q;
    logic [TOTAL_SUM_WIDTH-1:0]   r_total_sum;
    logic [TOTAL_COUNT_WIDTH-1:0] r_total_count;
    logic [ERR_W-1:0]           r_err;

    logic                       w_job_accept;
    logic                       w_grab;
    logic                       w_data_valid;
    logic                       w_all_requested;
    logic                       w_all_received;
    logic [TOTAL_SUM_WIDTH:0]   w_sum_add;
    logic [TOTAL_COUNT_WIDTH:0] w_cnt_add;

    assign w_job_accept = (r_state == ST_IDLE) && jobStart;

    // One read every other cycle: the FIFO's empty flag lags a read by a cycle.
    assign w_grab = (r_state == ST_COLLECT) && resultsAvailable && !w_all_requested && !r_grab_q;

    result_read_tracker #(
        .READ_LATENCY (READ_LATENCY)
    ) u_tracker (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_clear         (w_job_accept),
        .i_grab          (w_grab),
        .i_expected      (r_expected),
        .o_data_valid    (w_data_valid),
        .o_all_requested (w_all_requested),
        .o_all_received  (w_all_received)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_expected <= '0;
            r_grab_q   <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_grab_q <= w_grab;
            if (w_job_accept) begin
                r_expected <= jobBatchCount;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (jobStart) begin
                    w_next_state = (jobBatchCount == 32'd0) ? ST_EMIT : ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (w_all_requested) begin
                    w_next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_all_received) begin
                    w_next_state = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (totalReady) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Extra top bit of each adder is the carry-out that flags overflow.
    assign w_sum_add = {1'b0, r_total_sum}   + (TOTAL_SUM_WIDTH+1)'(pcoeffSum);
    assign w_cnt_add = {1'b0, r_total_count} + (TOTAL_COUNT_WIDTH+1)'(pcoeffCount);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_total_sum   <= '0;
            r_total_count <= '0;
            r_err         <= '0;
        end else begin
            if (w_job_accept) begin
                r_total_sum   <= '0;
                r_total_count <= '0;
            end else if (w_data_valid) begin
                r_total_sum   <= w_sum_add[TOTAL_SUM_WIDTH-1:0];
                r_total_count <= w_cnt_add[TOTAL_COUNT_WIDTH-1:0];
                if (w_sum_add[TOTAL_SUM_WIDTH] || w_cnt_add[TOTAL_COUNT_WIDTH]) begin
                    r_err[ERR_OVERFLOW] <= 1'b1;
                end
            end
            if (jobStart && (r_state != ST_IDLE)) begin
                r_err[ERR_START_BUSY] <= 1'b1;
            end
        end
    end

`ifdef PCOEFF_ACC_CHECKSUM_EN
    logic [31:0] r_checksum;

    function automatic logic [31:0] checksum_step(input logic [31:0] c,
                                                  input logic [31:0] s,
                                                  input logic [31:0] n);
        return {c[30:0], c[31]} ^ s ^ n;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_checksum <= '0;
        end else if (w_job_accept) begin
            r_checksum <= '0;
        end else if (w_data_valid) begin
            r_checksum <= checksum_step(r_checksum, pcoeffSum[31:0], 32'(pcoeffCount));
        end
    end

    assign totalChecksum = (r_state == ST_EMIT) ? r_checksum : 32'd0;
`else
    assign totalChecksum = 32'd0;
`endif

    assign grabResults = w_grab;
    assign totalValid  = (r_state == ST_EMIT);
    assign busy        = (r_state != ST_IDLE);
    assign totalSum    = r_total_sum;
    assign totalCount  = r_total_count;
    assign errFlags    = r_err;

endmodule

// File: tb/tb_pcoeff_result_accumulator.sv
// Directed bench for pcoeff_result_accumulator: a default instance and a narrow
// 46-bit-sum instance run in lockstep behind a behavioural 2-cycle-latency results FIFO.
module tb_pcoeff_result_accumulator;

    logic        clk;
    logic        rst_n;
    logic        jobStart;
    logic [31:0] jobBatchCount;
    logic        resultsAvailable;
    logic [45:0] pcoeffSum;
    logic [10:0] pcoeffCount;
    logic        totalReady;

    logic        grabA, validA, busyA;
    logic [63:0] sumA;
    logic [47:0] countA;
    logic [31:0] chkA;
    logic [1:0]  errA;

    logic        grabB, validB, busyB;
    logic [45:0] sumB;
    logic [47:0] countB;
    logic [31:0] chkB;
    logic [1:0]  errB;

    int n_checks = 0;
    int n_errors = 0;

    pcoeff_result_accumulator u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .jobStart         (jobStart),
        .jobBatchCount    (jobBatchCount),
        .resultsAvailable (resultsAvailable),
        .grabResults      (grabA),
        .pcoeffSum        (pcoeffSum[44:0]),
        .pcoeffCount      (pcoeffCount[9:0]),
        .totalValid       (validA),
        .totalReady       (totalReady),
        .totalSum         (sumA),
        .totalCount       (countA),
        .totalChecksum    (chkA),
        .busy             (busyA),
        .errFlags         (errA)
    );

    pcoeff_result_accumulator #(
        .PCOEFF_COUNT_BITWIDTH (11),
        .TOTAL_SUM_WIDTH       (46)
    ) u_dut_narrow (
        .clk              (clk),
        .rst_n            (rst_n),
        .jobStart         (jobStart),
        .jobBatchCount    (jobBatchCount),
        .resultsAvailable (resultsAvailable),
        .grabResults      (grabB),
        .pcoeffSum        (pcoeffSum),
        .pcoeffCount      (pcoeffCount),
        .totalValid       (validB),
        .totalReady       (totalReady),
        .totalSum         (sumB),
        .totalCount       (countB),
        .totalChecksum    (chkB),
        .busy             (busyB),
        .errFlags         (errB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Results FIFO model: registered read, data on the bus two cycles after a grab.
    logic [45:0] f_sum [16];
    logic [10:0] f_cnt [16];
    bit   [3:0]  f_wr;
    bit   [3:0]  f_rd;
    logic [45:0] s1_sum;
    logic [10:0] s1_cnt;
    int          grab_cnt  = 0;
    int          adj_cnt   = 0;
    int          grab_diff = 0;
    logic        grab_prev = 1'b0;

    assign resultsAvailable = (f_rd != f_wr);

    always @(posedge clk) begin
        if (!rst_n) begin
            f_rd        <= f_wr;
            s1_sum      <= '0;
            s1_cnt      <= '0;
            pcoeffSum   <= '0;
            pcoeffCount <= '0;
        end else begin
            if (grabA) begin
                f_rd     <= f_rd + 4'd1;
                s1_sum   <= f_sum[f_rd];
                s1_cnt   <= f_cnt[f_rd];
                grab_cnt <= grab_cnt + 1;
                if (grab_prev) adj_cnt <= adj_cnt + 1;
            end
            pcoeffSum   <= s1_sum;
            pcoeffCount <= s1_cnt;
        end
        if (grabA !== grabB) grab_diff <= grab_diff + 1;
        grab_prev <= grabA;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [45:0] s, input logic [10:0] c);
        f_sum[f_wr] = s;
        f_cnt[f_wr] = c;
        f_wr = f_wr + 4'd1;
    endtask

    task automatic start_job(input logic [31:0] count);
        jobBatchCount = count;
        jobStart = 1'b1;
        @(negedge clk);
        jobStart = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (!validA && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(validA), 64'd1);
    endtask

    task automatic handshake(input string tag);
        totalReady = 1'b1;
        @(negedge clk);
        totalReady = 1'b0;
        check(tag, 64'(validA), 64'd0);
    endtask

    logic [31:0] exp_chk1;
    logic [31:0] exp_chk6;
    int g0;
    int a0;
    int n;

    initial begin
`ifdef PCOEFF_ACC_CHECKSUM_EN
        exp_chk1 = 32'd18;
        exp_chk6 = 32'd3;
`else
        exp_chk1 = 32'd0;
        exp_chk6 = 32'd0;
`endif
        rst_n = 1'b0;
        jobStart = 1'b0;
        jobBatchCount = '0;
        totalReady = 1'b0;
        f_wr = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_busy",  64'(busyA),  64'd0);
        check("rst_valid", 64'(validA), 64'd0);
        check("rst_grab",  64'(grabA),  64'd0);
        check("rst_err",   64'(errA),   64'd0);
        check("rst_sum",   sumA,        64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: three results 5,7,11 / 1,2,3
        g0 = grab_cnt;
        a0 = adj_cnt;
        push(46'd5, 11'd1);
        push(46'd7, 11'd2);
        push(46'd11, 11'd3);
        start_job(32'd3);
        wait_valid("t1_wait", 40);
        check("t1_sum",   sumA,   64'd23);
        check("t1_count", 64'(countA), 64'd6);
        check("t1_grabs", 64'(grab_cnt - g0), 64'd3);
        check("t1_adjacent_grabs", 64'(adj_cnt - a0), 64'd0);
        check("t1_chk",   64'(chkA), 64'(exp_chk1));
        check("t1_err",   64'(errA), 64'd0);
        handshake("t1_hs");
        repeat (3) @(negedge clk);
        check("t1_single_valid", 64'(validA), 64'd0);
        check("t1_idle_busy",    64'(busyA),  64'd0);

        // 2: zero-batch job emits immediately
        g0 = grab_cnt;
        start_job(32'd0);
        check("t2_valid", 64'(validA), 64'd1);
        check("t2_sum",   sumA, 64'd0);
        check("t2_count", 64'(countA), 64'd0);
        check("t2_busy",  64'(busyA), 64'd1);
        handshake("t2_hs");
        check("t2_grabs", 64'(grab_cnt - g0), 64'd0);

        // 3: backpressure holds the total stable
        push(46'd1000, 11'd10);
        push(46'd2345, 11'd20);
        start_job(32'd2);
        wait_valid("t3_wait", 40);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t3_hold_valid", 64'(validA), 64'd1);
            check("t3_hold_sum",   sumA, 64'd3345);
            check("t3_hold_count", 64'(countA), 64'd30);
        end
        handshake("t3_hs");

        // 4: job consumes only its own batch count from a deeper FIFO
        g0 = grab_cnt;
        push(46'd100, 11'd4);
        push(46'd200, 11'd5);
        push(46'd300, 11'd6);
        push(46'd400, 11'd7);
        start_job(32'd2);
        wait_valid("t4_wait", 40);
        check("t4_sum",   sumA, 64'd300);
        check("t4_count", 64'(countA), 64'd9);
        handshake("t4_hs");
        repeat (4) @(negedge clk);
        check("t4_grabs",     64'(grab_cnt - g0), 64'd2);
        check("t4_remaining", 64'(4'(f_wr - f_rd)), 64'd2);
        check("t4_avail",     64'(resultsAvailable), 64'd1);

        // 5: reset while draining
        g0 = grab_cnt;
        start_job(32'd2);
        n = 0;
        while ((grab_cnt - g0) < 2 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("t5_reach_grabs", 64'(grab_cnt - g0), 64'd2);
        @(negedge clk);
        check("t5_busy_drain", 64'(busyA), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("t5_rst_busy",  64'(busyA),  64'd0);
        check("t5_rst_valid", 64'(validA), 64'd0);
        check("t5_rst_err",   64'(errA),   64'd0);
        check("t5_rst_sum",   sumA,        64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_fifo_flushed", 64'(resultsAvailable), 64'd0);
        push(46'd9, 11'd4);
        start_job(32'd1);
        wait_valid("t5_wait", 40);
        check("t5_sum",   sumA, 64'd9);
        check("t5_count", 64'(countA), 64'd4);
        handshake("t5_hs");

        // 6: overflow on the 46-bit accumulator, jobStart while busy
        start_job(32'd2);
        repeat (3) @(negedge clk);
        check("t6_stall_busy", 64'(busyA), 64'd1);
        check("t6_stall_grab", 64'(grabA), 64'd0);
        jobBatchCount = 32'd7;
        jobStart = 1'b1;
        @(negedge clk);
        jobStart = 1'b0;
        check("t6_err_busy_start", 64'(errA), 64'd2);
        push(46'h2000_0000_0000, 11'd1);
        push(46'h2000_0000_0000, 11'd1);
        wait_valid("t6_wait", 40);
        check("t6_narrow_sum",   64'(sumB),   64'd0);
        check("t6_narrow_err",   64'(errB),   64'd3);
        check("t6_narrow_count", 64'(countB), 64'd2);
        check("t6_narrow_valid", 64'(validB), 64'd1);
        check("t6_narrow_chk",   64'(chkB),   64'(exp_chk6));
        check("t6_count",        64'(countA), 64'd2);
        check("t6_sum",          sumA,        64'd0);
        check("t6_err",          64'(errA),   64'd2);
        check("t6_chk",          64'(chkA),   64'(exp_chk6));
        handshake("t6_hs");
        check("t6_narrow_busy",  64'(busyB),  64'd0);

        check("adjacent_grabs_total", 64'(adj_cnt), 64'd0);
        check("instances_grab_agree", 64'(grab_diff), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
